// File: rtl/seq_chunk_adder_pkg.sv
// Shared types and sizing helpers for the chunked add/subtract unit.
// Holds the FSM encoding and the chunk-count/index-width math.
package seq_chunk_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int nchunk_f(
        input int width,
        input int chunk
    );
        return width / chunk;
    endfunction

    // Index width never drops to zero, even for a single chunk.
    function automatic int idx_w_f(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_chunk_adder_chunk_adder.sv
// Combinational ripple of CHUNK full adders, time-shared by the FSM.
// c_msb is the carry into the top bit, needed for signed overflow.
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [CHUNK:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < CHUNK; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign co    = c[CHUNK];
    assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle add/subtract: CHUNK bits per clock, carry held between
// chunks, valid/ready on both sides, reports carry-out and overflow.
module seq_chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    import seq_chunk_adder_pkg::*;

    localparam int NCHUNK = nchunk_f(WIDTH, CHUNK);
    localparam int IW     = idx_w_f(NCHUNK);
    localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

    if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0)
    begin : g_bad_cfg
        $error("seq_chunk_adder: WIDTH must be a multiple of CHUNK");
    end

    state_t state;
    state_t state_nx;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [IW-1:0]    idx_q;
    logic             carry_q;
    logic             cout_q;
    logic             ovf_q;

    logic [CHUNK-1:0] s;
    logic             co;
    logic             c_msb;
    logic             accept;
    logic             step;
    logic             last;

    // Operands shift down so the active chunk always sits at bit 0.
    chunk_adder #(
        .CHUNK(CHUNK)
    ) u_add (
        .a    (a_q[CHUNK-1:0]),
        .b    (b_q[CHUNK-1:0]),
        .ci   (carry_q),
        .s    (s),
        .co   (co),
        .c_msb(c_msb)
    );

    if (NCHUNK > 1) begin : g_shift
        assign a_sh   = {{CHUNK{1'b0}}, a_q[WIDTH-1:CHUNK]};
        assign b_sh   = {{CHUNK{1'b0}}, b_q[WIDTH-1:CHUNK]};
        assign sum_sh = {s, sum_q[WIDTH-1:CHUNK]};
    end else begin : g_single
        assign a_sh   = a_q;
        assign b_sh   = b_q;
        assign sum_sh = s;
    end

    assign last      = (idx_q == LAST);
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        step     = 1'b0;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) state_nx = DONE;
            end
            DONE: begin
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Subtraction is a + ~b + ~borrow, so the datapath only ever adds.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b ^ {WIDTH{sub}};
            carry_q <= sub ? ~cin : cin;
            idx_q   <= '0;
        end else if (step) begin
            a_q     <= a_sh;
            b_q     <= b_sh;
            sum_q   <= sum_sh;
            carry_q <= co;
            if (last) begin
                cout_q <= co;
                ovf_q  <= co ^ c_msb;
            end else begin
                idx_q <= idx_q + IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Scoreboard bench: four configurations run directed and random ops
// against an arithmetic reference model with latency checking.
module tb_seq_chunk_adder;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    logic [3:0] done;

    task automatic chk(
        input int          cfg,
        input string       name,
        input logic [31:0] act,
        input logic [31:0] exp
    );
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL cfg%0d %s: got %0h want %0h (t=%0t)",
                     cfg, name, act, exp, $time);
        end
    endtask

    function automatic int cfg_w(input int g);
        return (g == 3) ? 32 : 16;
    endfunction

    function automatic int cfg_c(input int g);
        case (g)
            0:       return 4;
            1:       return 16;
            2:       return 1;
            default: return 8;
        endcase
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_cfg
        localparam int W  = cfg_w(g);
        localparam int C  = cfg_c(g);
        localparam int N  = W / C;
        localparam int RW = (N > 2) ? 2 : N - 1;

        logic rst, in_valid, in_ready, cin, sub;
        logic out_valid, out_ready, cout, ovf;
        logic [W-1:0] a, b, sum;
        logic ready_en, rnd_mode, fin;
        logic rnd_bit = 1'b0;
        logic seen = 1'b0;
        logic [W-1:0] h_sum;
        logic h_cout, h_ovf;
        exp_t q[$];

        assign out_ready = rnd_mode ? rnd_bit : ready_en;
        assign done[g]   = fin;

        seq_chunk_adder #(
            .WIDTH(W),
            .CHUNK(C)
        ) dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (in_valid),
            .in_ready (in_ready),
            .a        (a),
            .b        (b),
            .cin      (cin),
            .sub      (sub),
            .out_valid(out_valid),
            .out_ready(out_ready),
            .sum      (sum),
            .cout     (cout),
            .ovf      (ovf)
        );

        always @(negedge clk) rnd_bit <= 1'($urandom_range(0, 1));

        function automatic exp_t model(
            input logic [W-1:0] x,
            input logic [W-1:0] y,
            input logic         c,
            input logic         s,
            input int           acc
        );
            exp_t e;
            longint ua, ub, sa, sb, cl, r, sr, lim;
            ua  = x;
            ub  = y;
            sa  = $signed(x);
            sb  = $signed(y);
            cl  = c;
            lim = longint'(1) << (W - 1);
            if (!s) begin
                r      = ua + ub + cl;
                sr     = sa + sb + cl;
                e.cout = (r >> W) != 0;
            end else begin
                r      = ua - ub - cl;
                sr     = sa - sb - cl;
                e.cout = ua >= (ub + cl);
            end
            e.sum        = '0;
            e.sum[W-1:0] = r[W-1:0];
            e.ovf        = (sr >= lim) || (sr < -lim);
            e.acc        = acc;
            return e;
        endfunction

        function automatic logic [W-1:0] pick();
            logic [W-1:0] m;
            m = '1;
            m[W-1] = 1'b0;
            case ($urandom_range(0, 7))
                0:       return '1;
                1:       return m;
                2:       return ~m;
                3:       return '0;
                default: return W'({$urandom, $urandom});
            endcase
        endfunction

        task automatic issue(
            input logic [W-1:0] ta,
            input logic [W-1:0] tb,
            input logic         tc,
            input logic         ts
        );
            int k;
            in_valid = 1'b1;
            a   = ta;
            b   = tb;
            cin = tc;
            sub = ts;
            k = 0;
            while (!in_ready && k < 400) begin
                @(negedge clk);
                k++;
            end
            chk(g, "accept", in_ready, 1);
            if (in_ready) q.push_back(model(ta, tb, tc, ts, cyc + 1));
            @(negedge clk);
            in_valid = 1'b0;
            a   = W'($urandom);
            b   = W'($urandom);
            cin = 1'($urandom);
            sub = 1'($urandom);
        endtask

        task automatic wait_idle(input int lim);
            int k;
            k = 0;
            while (k < lim) begin
                if (q.size() == 0 && !out_valid) break;
                chk(g, "busy_in_ready", in_ready, 0);
                @(negedge clk);
                k++;
            end
            chk(g, "drain", q.size(), 0);
        endtask

        always @(negedge clk) begin
            if (!out_valid) begin
                seen <= 1'b0;
            end else if (!seen) begin
                seen   <= 1'b1;
                h_sum  <= sum;
                h_cout <= cout;
                h_ovf  <= ovf;
                if (q.size() == 0) begin
                    chk(g, "unexpected_valid", out_valid, 0);
                end else begin
                    chk(g, "sum", sum, q[0].sum);
                    chk(g, "cout", cout, q[0].cout);
                    chk(g, "ovf", ovf, q[0].ovf);
                    chk(g, "latency", cyc - q[0].acc, N);
                    void'(q.pop_front());
                end
            end else begin
                chk(g, "hold_sum", sum, h_sum);
                chk(g, "hold_cout", cout, h_cout);
                chk(g, "hold_ovf", ovf, h_ovf);
            end
        end

        initial begin
            logic [W-1:0] da[8];
            logic [W-1:0] db[8];
            logic         dc[8];
            logic         ds[8];
            logic [W-1:0] one, ones, maxp, minn;
            one  = 1;
            ones = '1;
            maxp = '1;
            maxp[W-1] = 1'b0;
            minn = ~maxp;
            da = '{W'(16'h1234), ones, maxp, '0, W'(5), minn, minn, '0};
            db = '{W'(16'h4321), one, one, '0, W'(7), one, minn, ones};
            dc = '{0, 0, 0, 1, 0, 0, 0, 1};
            ds = '{0, 0, 0, 0, 1, 1, 0, 1};

            fin      = 1'b0;
            rst      = 1'b1;
            in_valid = 1'b0;
            a        = '0;
            b        = '0;
            cin      = 1'b0;
            sub      = 1'b0;
            ready_en = 1'b1;
            rnd_mode = 1'b0;
            repeat (2) @(negedge clk);
            chk(g, "rst_out_valid", out_valid, 0);
            chk(g, "rst_in_ready", in_ready, 1);
            chk(g, "rst_sum", sum, 0);
            chk(g, "rst_cout", cout, 0);
            chk(g, "rst_ovf", ovf, 0);
            rst = 1'b0;
            @(negedge clk);

            for (int i = 0; i < 8; i++) begin
                issue(da[i], db[i], dc[i], ds[i]);
                wait_idle(100);
            end

            // Backpressure: result held, new request refused until idle.
            ready_en = 1'b0;
            issue(W'(16'hA5C3), W'(16'h1F0E), 1'b1, 1'b0);
            for (int k = 0; k < 100 && !out_valid; k++) @(negedge clk);
            chk(g, "bp_valid", out_valid, 1);
            in_valid = 1'b1;
            a   = one;
            b   = one;
            cin = 1'b0;
            sub = 1'b0;
            repeat (3) begin
                @(negedge clk);
                chk(g, "bp_in_ready", in_ready, 0);
            end
            ready_en = 1'b1;
            @(negedge clk);
            chk(g, "bp_drop_valid", out_valid, 0);
            chk(g, "bp_idle_ready", in_ready, 1);
            issue(one, one, 1'b0, 1'b0);
            wait_idle(100);

            // Reset mid-operation discards the result.
            issue(pick(), pick(), 1'b0, 1'b0);
            for (int k = 0; k < RW; k++) @(negedge clk);
            rst = 1'b1;
            void'(q.pop_back());
            @(negedge clk);
            rst = 1'b0;
            chk(g, "mid_rst_valid", out_valid, 0);
            chk(g, "mid_rst_ready", in_ready, 1);
            chk(g, "mid_rst_sum", sum, 0);
            issue(W'(16'h00FF), one, 1'b0, 1'b0);
            wait_idle(100);

            rnd_mode = 1'b1;
            repeat (1000) begin
                issue(pick(), pick(), 1'($urandom), 1'($urandom));
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            wait_idle(2000);
            rnd_mode = 1'b0;
            fin = 1'b1;
        end
    end

    initial begin
        int k;
        k = 0;
        while (done !== 4'hF && k < 95000) begin
            @(negedge clk);
            k++;
        end
        chk(-1, "all_done", done, 4'hF);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
